// File: rtl/workout_session_ctrl.sv
// rtl/workout_session_ctrl.sv - workout session sequencer: sample tick, sensor req/ack, emergency alarm, timeout tracking
module workout_session_ctrl #(
  parameter int CLK_DIV     = 50000000,
  parameter int ACK_TIMEOUT = 16,
  parameter int EMERG_COUNT = 3,
  parameter int HR_EMERG    = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        sens_ack,
  input  logic [7:0]  sens_hr,
  input  logic [1:0]  sens_steps,
  output logic        sens_req,
  output logic        calc_valid,
  output logic [7:0]  calc_hr,
  output logic [1:0]  calc_steps,
  output logic [2:0]  state,
  output logic [15:0] session_secs,
  output logic [7:0]  missed_samples,
  output logic        alarm,
  output logic        sensor_fault
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int EW = $clog2(EMERG_COUNT + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
  localparam logic [EW-1:0] EMERG_LAST = EW'(EMERG_COUNT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_PAUSE    = 3'd3,
    S_ALARM    = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [AW-1:0]   to_cnt_q, to_cnt_d;
  logic [EW-1:0]   emerg_q, emerg_d;
  logic [2:0]      miss_q, miss_d;
  logic            pause_seen_q, pause_seen_d;
  logic [15:0]     secs_q, secs_d;
  logic [7:0]      missed_q, missed_d;
  logic            alarm_q, alarm_d;
  logic            fault_q, fault_d;
  logic            cvalid_q, cvalid_d;
  logic [7:0]      chr_q, chr_d;
  logic [1:0]      csteps_q, csteps_d;

  logic            counting, tick, in_wait, accept, timeout, hr_high;
  logic            emerg_hit, session_start;
  logic [EW-1:0]   emerg_inc;

  always_comb begin
    counting      = (state_q == S_RUN) || (state_q == S_WAIT_ACK);
    tick          = counting && (tick_cnt_q == TICK_LAST);
    in_wait       = (state_q == S_WAIT_ACK);
    // stop wins over a same-cycle ack, so the sample is discarded
    accept        = in_wait && sens_ack && !stop;
    timeout       = in_wait && !sens_ack && !stop && (to_cnt_q == ACK_LAST);
    hr_high       = int'(sens_hr) > HR_EMERG;
    emerg_inc     = emerg_q + EW'(1);
    emerg_hit     = accept && hr_high && (emerg_inc == EMERG_LAST);
    session_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !stop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (session_start) state_d = S_RUN;
      S_RUN: begin
        if (stop)       state_d = S_DONE;
        else if (pause) state_d = S_PAUSE;
        else if (tick)  state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (stop)                    state_d = S_DONE;
        else if (emerg_hit)          state_d = S_ALARM;
        else if (accept || timeout)  state_d = (pause_seen_q || pause) ? S_PAUSE : S_RUN;
      end
      S_PAUSE: begin
        if (stop)                 state_d = S_DONE;
        else if (start && !pause) state_d = S_RUN;
      end
      S_ALARM: if (stop) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    to_cnt_d     = to_cnt_q;
    emerg_d      = emerg_q;
    miss_d       = miss_q;
    pause_seen_d = pause_seen_q;
    secs_d       = secs_q;
    missed_d     = missed_q;
    alarm_d      = alarm_q;
    fault_d      = fault_q;
    chr_d        = chr_q;
    csteps_d     = csteps_q;
    cvalid_d     = accept;
    if (session_start) begin
      tick_cnt_d   = '0;
      to_cnt_d     = '0;
      emerg_d      = '0;
      miss_d       = '0;
      pause_seen_d = 1'b0;
      secs_d       = '0;
      missed_d     = '0;
      alarm_d      = 1'b0;
      fault_d      = 1'b0;
    end else begin
      if (counting) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      if (state_q == S_RUN) begin
        to_cnt_d     = '0;
        pause_seen_d = 1'b0;
      end
      if (in_wait) begin
        to_cnt_d = to_cnt_q + AW'(1);
        if (pause) pause_seen_d = 1'b1;
      end
      if (accept) begin
        chr_d    = sens_hr;
        csteps_d = sens_steps;
        miss_d   = '0;
        emerg_d  = hr_high ? emerg_inc : '0;
        if (secs_q != 16'hFFFF) secs_d = secs_q + 16'd1;
        if (emerg_hit) alarm_d = 1'b1;
      end
      // timeouts leave the emergency streak untouched
      if (timeout) begin
        if (missed_q != 8'hFF) missed_d = missed_q + 8'd1;
        if (miss_q != 3'd4)    miss_d   = miss_q + 3'd1;
        if (miss_q >= 3'd3)    fault_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      to_cnt_q     <= '0;
      emerg_q      <= '0;
      miss_q       <= '0;
      pause_seen_q <= 1'b0;
      secs_q       <= '0;
      missed_q     <= '0;
      alarm_q      <= 1'b0;
      fault_q      <= 1'b0;
      cvalid_q     <= 1'b0;
      chr_q        <= '0;
      csteps_q     <= '0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      to_cnt_q     <= to_cnt_d;
      emerg_q      <= emerg_d;
      miss_q       <= miss_d;
      pause_seen_q <= pause_seen_d;
      secs_q       <= secs_d;
      missed_q     <= missed_d;
      alarm_q      <= alarm_d;
      fault_q      <= fault_d;
      cvalid_q     <= cvalid_d;
      chr_q        <= chr_d;
      csteps_q     <= csteps_d;
    end
  end

  always_comb begin
    sens_req       = (state_q == S_WAIT_ACK);
    calc_valid     = cvalid_q;
    calc_hr        = chr_q;
    calc_steps     = csteps_q;
    state          = state_q;
    session_secs   = secs_q;
    missed_samples = missed_q;
    alarm          = alarm_q;
    sensor_fault   = fault_q;
  end

endmodule
